// File: rtl/mem_word.sv
`default_nettype none
// ============================================================================
// Module   : mem_word
// Purpose  : One addressable storage word of a memory array. A WIDTH-bit
//            register is written or read under a word-select line and a shared
//            read/write strobe. The array ORs every word's o bus together, so
//            an unselected or non-reading word drives zeros.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   WIDTH    - data width of the stored word, i and o
//   RST_VAL  - value loaded into the storage register on reset
// Ports:
//   clk      in   1      system clock, rising edge
//   rst_n    in   1      asynchronous active-low reset
//   RW       in   1      1 = read, 0 = write (only meaningful with select=1)
//   select   in   1      word enable from the address decoder
//   i        in   WIDTH  write data
//   o        out  WIDTH  registered read data, zero when not reading
//   rd_valid out  1      o carries valid read data this cycle
//   written  out  1      word written at least once since reset
//   par_o    out  1      even parity of o (present only with MEM_WORD_PARITY_EN)
// Build option:
//   MEM_WORD_PARITY_EN - when defined, a parity bit is stored with the word on
//                        every write and returned on par_o alongside o.
// ============================================================================
module mem_word #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RW,
  input  logic             select,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] o,
  output logic             rd_valid,
  output logic             written
`ifdef MEM_WORD_PARITY_EN
  ,
  output logic             par_o
`endif
);

  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             rd_valid_q, rd_valid_d;
  logic             written_q, written_d;

  logic             w_wr_en;
  logic             w_rd_en;

  assign w_wr_en = select & ~RW;
  assign w_rd_en = select &  RW;

  // o is driven only on a read cycle; every other cycle it returns to zero so
  // the array-level OR of all words is not corrupted by idle words.
  always_comb begin
    word_d     = word_q;
    written_d  = written_q;
    o_d        = '0;
    rd_valid_d = 1'b0;
    if (w_wr_en) begin
      word_d    = i;
      written_d = 1'b1;
    end else if (w_rd_en) begin
      o_d        = word_q;
      rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q     <= RST_VAL;
      o_q        <= '0;
      rd_valid_q <= 1'b0;
      written_q  <= 1'b0;
    end else begin
      word_q     <= word_d;
      o_q        <= o_d;
      rd_valid_q <= rd_valid_d;
      written_q  <= written_d;
    end
  end

  assign o        = o_q;
  assign rd_valid = rd_valid_q;
  assign written  = written_q;

`ifdef MEM_WORD_PARITY_EN
  // The parity bit makes the total count of ones (word plus parity) even, so
  // it is simply the XOR reduction of the data it protects.
  localparam logic RST_PAR = ^RST_VAL;

  logic par_store_q, par_store_d;
  logic par_out_q, par_out_d;

  always_comb begin
    par_store_d = par_store_q;
    par_out_d   = 1'b0;
    if (w_wr_en) begin
      par_store_d = ^i;
    end else if (w_rd_en) begin
      par_out_d = par_store_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_store_q <= RST_PAR;
      par_out_q   <= 1'b0;
    end else begin
      par_store_q <= par_store_d;
      par_out_q   <= par_out_d;
    end
  end

  assign par_o = par_out_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_word.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_word
// Purpose  : Self-checking bench for mem_word. A behavioural model (one stored
//            value, a written flag and the expected registered outputs) is
//            advanced once per clock and compared against the DUT outputs
//            one time unit after each rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_word;

  localparam int             W       = 8;
  localparam logic [W-1:0]   RST_VAL = 8'hA5;

  logic         clk;
  logic         rst_n;
  logic         RW;
  logic         select;
  logic [W-1:0] i;
  logic [W-1:0] o;
  logic         rd_valid;
  logic         written;
`ifdef MEM_WORD_PARITY_EN
  logic         par_o;
`endif

  mem_word #(
    .WIDTH   (W),
    .RST_VAL (RST_VAL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RW       (RW),
    .select   (select),
    .i        (i),
    .o        (o),
    .rd_valid (rd_valid),
    .written  (written)
`ifdef MEM_WORD_PARITY_EN
    ,
    .par_o    (par_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [W-1:0] m_word;
  logic         m_written;
  logic [W-1:0] exp_o;
  logic         exp_v;

  task automatic model_reset();
    m_word    = RST_VAL;
    m_written = 1'b0;
    exp_o     = '0;
    exp_v     = 1'b0;
  endtask

  // Apply one cycle of stimulus and advance the model. Returns with time
  // positioned one unit after the rising edge, ready for sampling.
  task automatic drive(input logic s, input logic r, input logic [W-1:0] d);
    @(negedge clk);
    select = s;
    RW     = r;
    i      = d;
    @(posedge clk);
    #1;
    if (s && r) begin
      exp_o = m_word;
      exp_v = 1'b1;
    end else begin
      exp_o = '0;
      exp_v = 1'b0;
    end
    if (s && !r) begin
      m_word    = d;
      m_written = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; select = 1'b0; RW = 1'b0; i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (o !== 8'h00) begin n_fail++; $display("FAIL reset_o actual=%h expected=%h", o, 8'h00); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid actual=%b expected=0", rd_valid); end
    n_cmp++; if (written !== 1'b0) begin n_fail++; $display("FAIL reset_written actual=%b expected=0", written); end
`ifdef MEM_WORD_PARITY_EN
    n_cmp++; if (par_o !== 1'b0) begin n_fail++; $display("FAIL reset_par actual=%b expected=0", par_o); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    // idle cycle with nonzero data on i
    drive(1'b0, 1'b0, 8'd9);
    n_cmp++; if (o !== 8'h00 || rd_valid !== 1'b0 || written !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset actual=o:%h v:%b w:%b expected=o:00 v:0 w:0", o, rd_valid, written);
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 1'b0, 8'd4);
    n_cmp++; if (written !== 1'b1 || o !== 8'h00 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL write4 actual=o:%h v:%b w:%b expected=o:00 v:0 w:1", o, rd_valid, written);
    end
    drive(1'b1, 1'b1, 8'd3);
    n_cmp++; if (o !== 8'd4 || rd_valid !== 1'b1) begin
      n_fail++; $display("FAIL read4 actual=o:%h v:%b expected=o:04 v:1", o, rd_valid);
    end
  endtask

  task automatic test_idle_holds();
    drive(1'b0, 1'b1, 8'd2);
    n_cmp++; if (o !== 8'h00 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_read actual=o:%h v:%b expected=o:00 v:0", o, rd_valid);
    end
    drive(1'b0, 1'b0, 8'd5);
    drive(1'b1, 1'b1, 8'd0);
    n_cmp++; if (o !== 8'd4 || rd_valid !== 1'b1) begin
      n_fail++; $display("FAIL idle_hold actual=o:%h v:%b expected=o:04 v:1", o, rd_valid);
    end
    drive(1'b1, 1'b0, 8'd8);
    drive(1'b1, 1'b1, 8'd0);
    n_cmp++; if (o !== 8'd8) begin n_fail++; $display("FAIL read8 actual=%h expected=08", o); end
    drive(1'b0, 1'b0, 8'd0);
    n_cmp++; if (o !== 8'h00 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL deselect1 actual=o:%h v:%b expected=o:00 v:0", o, rd_valid);
    end
    drive(1'b0, 1'b1, 8'hFF);
    n_cmp++; if (o !== 8'h00) begin n_fail++; $display("FAIL deselect2 actual=%h expected=00", o); end
    drive(1'b1, 1'b1, 8'd0);
    n_cmp++; if (o !== 8'd8) begin n_fail++; $display("FAIL keep8 actual=%h expected=08", o); end
  endtask

  task automatic test_back_to_back();
    // write then immediate read, then consecutive reads
    drive(1'b1, 1'b0, 8'h3C);
    drive(1'b1, 1'b1, 8'h00);
    n_cmp++; if (o !== 8'h3C || rd_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_read actual=o:%h v:%b expected=o:3c v:1", o, rd_valid);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 8'(k));
      n_cmp++; if (o !== 8'h3C || rd_valid !== 1'b1) begin
        n_fail++; $display("FAIL consec_read%0d actual=o:%h v:%b expected=o:3c v:1", k, o, rd_valid);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 8'h00);
    // reset between edges while o is showing read data
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (o !== 8'h00 || rd_valid !== 1'b0 || written !== 1'b0) begin
      n_fail++; $display("FAIL async_reset actual=o:%h v:%b w:%b expected=o:00 v:0 w:0", o, rd_valid, written);
    end
`ifdef MEM_WORD_PARITY_EN
    n_cmp++; if (par_o !== 1'b0) begin n_fail++; $display("FAIL async_reset_par actual=%b expected=0", par_o); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 8'h11);
    n_cmp++; if (o !== RST_VAL || rd_valid !== 1'b1 || written !== 1'b0) begin
      n_fail++; $display("FAIL read_rst_val actual=o:%h v:%b w:%b expected=o:%h v:1 w:0", o, rd_valid, written, RST_VAL);
    end
`ifdef MEM_WORD_PARITY_EN
    n_cmp++; if (par_o !== ^RST_VAL) begin n_fail++; $display("FAIL rst_par actual=%b expected=%b", par_o, ^RST_VAL); end
`endif
  endtask

  task automatic test_random();
    logic s, r;
    logic [W-1:0] d;
    for (int k = 0; k < 300; k++) begin
      s = 1'($urandom_range(0, 3) != 0);
      r = 1'($urandom_range(0, 1));
      d = W'($urandom);
      drive(s, r, d);
      n_cmp++; if (o !== exp_o || rd_valid !== exp_v || written !== m_written) begin
        n_fail++;
        $display("FAIL random%0d actual=o:%h v:%b w:%b expected=o:%h v:%b w:%b",
                 k, o, rd_valid, written, exp_o, exp_v, m_written);
      end
`ifdef MEM_WORD_PARITY_EN
      n_cmp++; if (par_o !== ^exp_o) begin
        n_fail++; $display("FAIL random_par%0d actual=%b expected=%b", k, par_o, ^exp_o);
      end
`endif
    end
  endtask

`ifdef MEM_WORD_PARITY_EN
  task automatic test_parity();
    drive(1'b1, 1'b0, 8'h07);
    drive(1'b1, 1'b1, 8'h00);
    n_cmp++; if (o !== 8'h07 || par_o !== 1'b1) begin
      n_fail++; $display("FAIL par07 actual=o:%h p:%b expected=o:07 p:1", o, par_o);
    end
    drive(1'b1, 1'b0, 8'h03);
    drive(1'b1, 1'b1, 8'h00);
    n_cmp++; if (o !== 8'h03 || par_o !== 1'b0) begin
      n_fail++; $display("FAIL par03 actual=o:%h p:%b expected=o:03 p:0", o, par_o);
    end
    drive(1'b0, 1'b1, 8'h00);
    n_cmp++; if (par_o !== 1'b0) begin n_fail++; $display("FAIL par_idle actual=%b expected=0", par_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_idle_holds();
    test_back_to_back();
    test_async_reset();
`ifdef MEM_WORD_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard bound on total run time in case the clock or a task stalls.
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
